// File: rtl/menu_select_ctrl.sv
// Menu navigation controller: synchronises and debounces four push buttons,
// then steps a highlight index through the menu and confirms a choice.
module menu_select_ctrl #(
  parameter int NUM_ITEMS       = 3,
  parameter int DEBOUNCE_CYCLES = 125000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnC,
  input  logic       btnL,
  output logic       showmenu,
  output logic [3:0] highlight,
  output logic [3:0] choice,
  output logic       choice_valid
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]      LAST_IDX = 4'(NUM_ITEMS - 1);

  localparam logic [0:0] MENU   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  // Button lanes: 0 = up, 1 = down, 2 = centre, 3 = back.
  localparam int B_UP = 0;
  localparam int B_DN = 1;
  localparam int B_CT = 2;
  localparam int B_BK = 3;

  logic [3:0]    raw;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    level;
  logic [3:0]    level_q;
  logic [3:0]    press;
  logic [CW-1:0] cnt [4];
  logic [0:0]    state;

  assign raw = {btnL, btnC, btnD, btnU};

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from pre-edge values and simulation ordering cannot change results.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // A level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  for (genvar b = 0; b < 4; b++) begin : g_debounce
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt[b]   <= '0;
        level[b] <= 1'b0;
      end else if (sync2[b] != level[b]) begin
        if (cnt[b] == CNT_LAST) begin
          cnt[b]   <= '0;
          level[b] <= sync2[b];
        end else begin
          cnt[b] <= cnt[b] + 1'b1;
        end
      end else begin
        cnt[b] <= '0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_q <= '0;
      press   <= '0;
    end else begin
      level_q <= level;
      press   <= level & ~level_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= MENU;
      showmenu     <= 1'b1;
      highlight    <= '0;
      choice       <= '0;
      choice_valid <= 1'b0;
    end else begin
      // NOTE: default-low here makes choice_valid a single-cycle pulse.
      choice_valid <= 1'b0;
      case (state)
        MENU: begin
          if (press[B_CT]) begin
            choice       <= highlight + 4'd1;
            choice_valid <= 1'b1;
            state        <= ACTIVE;
            showmenu     <= 1'b0;
          end else if (press[B_BK]) begin
            // Back outranks up/down but has nothing to do on the menu screen.
            state <= MENU;
          end else if (press[B_UP] && !press[B_DN]) begin
            highlight <= (highlight == 4'd0) ? LAST_IDX : highlight - 4'd1;
          end else if (press[B_DN] && !press[B_UP]) begin
            highlight <= (highlight == LAST_IDX) ? 4'd0 : highlight + 4'd1;
          end
        end
        default: begin
          if (press[B_BK]) begin
            state    <= MENU;
            showmenu <= 1'b1;
            choice   <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_menu_select_ctrl.sv
// Bench for menu_select_ctrl: directed scenarios plus randomised button
// activity, compared every cycle against a behavioural model.
module tb_menu_select_ctrl;

  localparam int N = 3;
  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       btnU = 1'b0, btnD = 1'b0, btnC = 1'b0, btnL = 1'b0;
  logic       showmenu, choice_valid;
  logic [3:0] highlight, choice;

  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  int h1[4], h2[4], lvl[4], run[4], soon[4], due[4];
  int m_menu, m_hl, m_choice, m_cv;

  menu_select_ctrl #(.NUM_ITEMS(N), .DEBOUNCE_CYCLES(D)) dut (
    .clock(clock), .reset(reset),
    .btnU(btnU), .btnD(btnD), .btnC(btnC), .btnL(btnL),
    .showmenu(showmenu), .highlight(highlight),
    .choice(choice), .choice_valid(choice_valid)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 4; b++) begin
      h1[b] = 0; h2[b] = 0; lvl[b] = 0; run[b] = 0; soon[b] = 0; due[b] = 0;
    end
    m_menu = 1; m_hl = 0; m_choice = 0; m_cv = 0;
  endtask

  // One clock edge of the reference: a button's press takes effect on the
  // outputs two edges after its debounced level rises.
  task automatic model_edge(input logic [3:0] rawv);
    int act[4];
    int s;
    for (int b = 0; b < 4; b++) begin
      act[b]  = due[b];
      due[b]  = soon[b];
      soon[b] = 0;
      s       = h2[b];
      h2[b]   = h1[b];
      h1[b]   = int'(rawv[b]);
      if (s != lvl[b]) begin
        run[b]++;
        if (run[b] == D) begin
          lvl[b] = s;
          run[b] = 0;
          if (s == 1) soon[b] = 1;
        end
      end else begin
        run[b] = 0;
      end
    end
    m_cv = 0;
    if (m_menu == 1) begin
      if (act[2] == 1) begin
        m_choice = m_hl + 1; m_cv = 1; m_menu = 0;
      end else if (act[3] == 1) begin
        m_menu = 1;
      end else if (act[0] == 1 && act[1] == 0) begin
        m_hl = (m_hl + N - 1) % N;
      end else if (act[1] == 1 && act[0] == 0) begin
        m_hl = (m_hl + 1) % N;
      end
    end else if (act[3] == 1) begin
      m_menu = 1; m_choice = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".showmenu"},     32'(showmenu),     32'(m_menu));
    check({tag, ".highlight"},    32'(highlight),    32'(m_hl));
    check({tag, ".choice"},       32'(choice),       32'(m_choice));
    check({tag, ".choice_valid"}, 32'(choice_valid), 32'(m_cv));
  endtask

  task automatic tick(input string tag);
    @(posedge clock);
    model_edge({btnL, btnC, btnD, btnU});
    @(negedge clock);
    compare_all(tag);
  endtask

  task automatic set_btns(input logic [3:0] v);
    {btnL, btnC, btnD, btnU} = v;
  endtask

  // Called at a negedge: asserts reset, checks the async clear, releases.
  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    compare_all("reset_async");
    repeat (2) @(posedge clock);
    @(negedge clock);
    compare_all("reset_hold");
    reset = 1'b0;
  endtask

  task automatic press(input logic [3:0] v, input int hold, input string tag);
    set_btns(v);
    repeat (hold) tick(tag);
    set_btns(4'b0000);
    repeat (8) tick(tag);
  endtask

  initial begin
    logic [3:0] vec;
    model_reset();
    @(negedge clock);
    do_reset();

    repeat (12) tick("idle");
    check("idle_hl", 32'(highlight), 32'd0);

    // Down held: output changes on edge D+4 exactly.
    set_btns(4'b0010);
    repeat (7) tick("d_hold");
    check("d_edge7", 32'(highlight), 32'd0);
    tick("d_hold");
    check("d_edge8", 32'(highlight), 32'd1);
    repeat (6) tick("d_hold");
    check("d_held", 32'(highlight), 32'd1);
    set_btns(4'b0000);
    repeat (8) tick("d_rel");
    press(4'b0010, 6, "d2");
    check("d_second", 32'(highlight), 32'd2);
    press(4'b0010, 6, "d3");
    check("d_wrap", 32'(highlight), 32'd0);

    // Glitch shorter than the debounce interval is ignored; a real press wraps.
    press(4'b0001, 3, "u_glitch");
    check("u_glitch_hl", 32'(highlight), 32'd0);
    press(4'b0001, 6, "u_wrap");
    check("u_wrap_hl", 32'(highlight), 32'd2);

    // Confirm, ignored navigation while active, then back.
    set_btns(4'b0100);
    repeat (7) tick("c_conf");
    check("c_pre_valid", 32'(choice_valid), 32'd0);
    tick("c_conf");
    check("c_valid", 32'(choice_valid), 32'd1);
    check("c_choice", 32'(choice), 32'd3);
    check("c_show", 32'(showmenu), 32'd0);
    tick("c_conf");
    check("c_valid_once", 32'(choice_valid), 32'd0);
    set_btns(4'b0000);
    repeat (8) tick("c_rel");
    press(4'b0010, 6, "act_d");
    check("act_d_hl", 32'(highlight), 32'd2);
    check("act_d_choice", 32'(choice), 32'd3);
    press(4'b1000, 6, "back");
    check("back_show", 32'(showmenu), 32'd1);
    check("back_choice", 32'(choice), 32'd0);
    check("back_hl", 32'(highlight), 32'd2);

    // Centre and down together: centre wins.
    press(4'b0010, 6, "to0");
    check("to0_hl", 32'(highlight), 32'd0);
    press(4'b0110, 6, "cd");
    check("cd_choice", 32'(choice), 32'd1);
    check("cd_hl", 32'(highlight), 32'd0);
    check("cd_show", 32'(showmenu), 32'd0);
    press(4'b1000, 6, "cd_back");

    // Reset mid-debounce with the button kept held through release.
    set_btns(4'b0010);
    repeat (2) tick("rst_mid");
    do_reset();
    repeat (7) tick("rst_rel");
    check("rst_edge7", 32'(highlight), 32'd0);
    tick("rst_rel");
    check("rst_edge8", 32'(highlight), 32'd1);
    set_btns(4'b0000);
    repeat (8) tick("rst_rel");

    // Randomised activity; back is never started together with up/down.
    for (int seg = 0; seg < 300; seg++) begin
      vec = 4'($urandom_range(0, 15));
      if (vec[3]) vec[1:0] = 2'b00;
      set_btns(vec);
      repeat ($urandom_range(1, 10)) tick("rand");
      if ($urandom_range(0, 39) == 0) do_reset();
      if ($urandom_range(0, 2) == 0) begin
        set_btns(4'b0000);
        repeat ($urandom_range(1, 8)) tick("rand_gap");
      end
    end
    set_btns(4'b0000);
    repeat (10) tick("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/menu_select_ctrl.md
MENU_SELECT_CTRL -- requirements
Module: menu_select_ctrl

Interface
REQ-001 SHALL have parameter NUM_ITEMS, default 3, meaning the number of selectable menu entries (legal range 1..15).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 125000, meaning consecutive stable clock cycles required to accept a button level change (20 ms at 6.25 MHz).
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port btnU, input, 1 bit: raw, unsynchronised up button, high = pressed.
REQ-006 SHALL have port btnD, input, 1 bit: raw down button.
REQ-007 SHALL have port btnC, input, 1 bit: raw centre/confirm button.
REQ-008 SHALL have port btnL, input, 1 bit: raw back button.
REQ-009 SHALL have port showmenu, output, 1 bit: high while the menu screen is to be drawn by the menu display stage.
REQ-010 SHALL have port highlight, output, 4 bits: index (0..NUM_ITEMS-1) of the currently highlighted entry.
REQ-011 SHALL have port choice, output, 4 bits: confirmed selection, 1..NUM_ITEMS; 0 means none.
REQ-012 SHALL have port choice_valid, output, 1 bit: single-cycle pulse marking a new confirmed choice.

Function
REQ-013 SHALL pass each button through a 2-flop synchroniser before any other use.
REQ-014 SHALL hold a debounced level per button, changed only after the synchronised value differs from it for DEBOUNCE_CYCLES consecutive edges; any cycle of agreement SHALL clear that button's counter.
REQ-015 SHALL generate a registered one-cycle press pulse per button on each 0->1 transition of its debounced level; a held button SHALL produce exactly one pulse.
REQ-016 SHALL implement two states: MENU (showmenu=1) and ACTIVE (showmenu=0).
REQ-017 In MENU, a btnU press SHALL decrement highlight, wrapping 0 -> NUM_ITEMS-1.
REQ-018 In MENU, a btnD press SHALL increment highlight, wrapping NUM_ITEMS-1 -> 0.
REQ-019 In MENU, a btnC press SHALL set choice = highlight+1, pulse choice_valid for exactly one cycle, and enter ACTIVE on the same edge.
REQ-020 In ACTIVE, btnU, btnD and btnC presses SHALL be ignored; a btnL press SHALL return to MENU, set choice=0, and leave highlight unchanged.
REQ-021 In MENU, btnL presses SHALL be ignored.
REQ-022 Simultaneous press pulses SHALL resolve with priority btnC > btnL > (btnU, btnD); btnU and btnD pulsing together SHALL leave highlight unchanged.
REQ-023 All outputs SHALL be registered; the output change SHALL occur on edge DEBOUNCE_CYCLES+4, counting as edge 1 the first edge at which the raw button is sampled high.
REQ-024 With NUM_ITEMS=1, up/down presses SHALL leave highlight at 0.
REQ-025 choice_valid SHALL never be high for two consecutive cycles.

Reset
REQ-026 On reset assertion, asynchronously: state=MENU, showmenu=1, highlight=0, choice=0, choice_valid=0, synchronisers, debounced levels, press pulses and counters=0.
REQ-027 Reset asserted mid-debounce or mid-pulse SHALL discard the pending event; a button still held at reset release SHALL register one press after a full debounce interval.

Verification (DEBOUNCE_CYCLES=4, NUM_ITEMS=3)
REQ-028 Reset release, no buttons -> showmenu=1, highlight=0, choice=0, choice_valid=0 indefinitely.
REQ-029 btnD held high from edge 1 -> highlight becomes 1 at edge 8 exactly; stays 1 while held; three separate presses from 0 -> 1, 2, 0.
REQ-030 btnU pulse high for 3 cycles (glitch) -> highlight unchanged; btnU held from highlight=0 -> highlight=2.
REQ-031 highlight=2, btnC press -> choice=3, choice_valid high for one cycle, showmenu=0; then btnD press -> no change; btnL press -> showmenu=1, choice=0, highlight=2.
REQ-032 btnC and btnD rise on the same edge in MENU with highlight=0 -> choice=1, highlight=0, state ACTIVE.
REQ-033 Reset asserted with btnD held 2 cycles into debounce -> no highlight change; btnD kept held through release -> highlight=1 on edge 8 after release.
